// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Control bundle between the MiniMIPS multicycle main control
//                unit and the datapath / memory.
//                  - opcode, mem_ready     : datapath -> control
//                  - ALUop, ALUSrcA/B, PCSource, datapath enables,
//                    illegal, halted, state: control -> datapath
//                The master modport is the control unit.
//                The slave modport is the datapath side.
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if;

  // Inputs to the control unit
  logic [3:0] opcode;     // IR[15:12]
  logic       mem_ready;  // memory finishes the current access this cycle

  // ALU / mux selects
  logic [2:0] ALUop;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;

  // Datapath enables
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNe;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;

  // Status / debug
  logic       illegal;
  logic       halted;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output ALUop, ALUSrcA, ALUSrcB, PCSource,
    output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
    output IRWrite, MemtoReg, RegDst, RegWrite,
    output illegal, halted, state
  );

  modport slave (
    output opcode, mem_ready,
    input  ALUop, ALUSrcA, ALUSrcB, PCSource,
    input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
    input  IRWrite, MemtoReg, RegDst, RegWrite,
    input  illegal, halted, state
  );

endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multicycle main control unit for MiniMIPS. A Moore FSM that
//                sequences fetch, decode, execute, memory and write-back, and
//                drives datapath selects/enables plus the 3-bit ALUop.
//  Ports       :
//    clk    in  rising-edge clock
//    reset  in  asynchronous active-high reset, forces IDLE immediately
//    bus    master modport of multicycle_control_if
//           (opcode/mem_ready in; ALU selects, enables, illegal,
//            halted and state out)
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control (
  input  wire logic            clk,
  input  wire logic            reset,
  multicycle_control_if.master bus
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_ANDI  = 4'b0010;
  localparam logic [3:0] OP_ORI   = 4'b0011;
  localparam logic [3:0] OP_SLTI  = 4'b0100;
  localparam logic [3:0] OP_LW    = 4'b0101;
  localparam logic [3:0] OP_SW    = 4'b0110;
  localparam logic [3:0] OP_BEQ   = 4'b0111;
  localparam logic [3:0] OP_BNE   = 4'b1000;
  localparam logic [3:0] OP_J     = 4'b1001;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_ONE    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Registered Moore outputs. pc_write here is only the unconditional
  // jump write; the fetch-time PC update is a separate mem_ready strobe.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       halted;
  } ctrl_t;

  // --------------------------------------------------------------------------
  // Output decode for a given state / latched opcode. Anything not listed
  // stays 0, including the unreachable encodings 14-15.
  // --------------------------------------------------------------------------
  function automatic ctrl_t ctrl_for(input state_t s, input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_ONE;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        // Speculative branch-target computation into ALUOut
        c.alu_src_b = SRCB_BRANCH;
        c.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = ALU_RTYPE;
      end
      S_WB_R: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        case (op)
          OP_ANDI: c.alu_op = ALU_AND;
          OP_ORI:  c.alu_op = ALU_OR;
          OP_SLTI: c.alu_op = ALU_SLT;
          default: c.alu_op = ALU_ADD;   // addi
        endcase
      end
      S_WB_I: begin
        c.reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REGB;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.branch_ne     = (op == OP_BNE);
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      S_HALT: begin
        c.halted = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       opcode_legal;
  logic       fetch_done;

  // 1010-1110 are the only unmapped opcodes
  assign opcode_legal = (bus.opcode < 4'b1010) || (bus.opcode == OP_HALT);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = bus.opcode;
        case (bus.opcode)
          OP_RTYPE:                          state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_HALT:                           state_d = S_HALT;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     state_d = S_FETCH;
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;   // recover from 14/15
    endcase
    // Outputs are precomputed for the state being entered so that they come
    // straight from flops; op_d already holds the opcode captured in DECODE.
    ctrl_d = ctrl_for(state_d, op_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 4'b0000;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // IR load and PC+1 happen in the one FETCH cycle where memory completes.
  assign fetch_done = (state_q == S_FETCH) && bus.mem_ready;

  assign bus.ALUop       = ctrl_q.alu_op;
  assign bus.ALUSrcA     = ctrl_q.alu_src_a;
  assign bus.ALUSrcB     = ctrl_q.alu_src_b;
  assign bus.PCSource    = ctrl_q.pc_source;
  assign bus.PCWrite     = ctrl_q.pc_write | fetch_done;
  assign bus.PCWriteCond = ctrl_q.pc_write_cond;
  assign bus.BranchNe    = ctrl_q.branch_ne;
  assign bus.IorD        = ctrl_q.i_or_d;
  assign bus.MemRead     = ctrl_q.mem_read;
  assign bus.MemWrite    = ctrl_q.mem_write;
  assign bus.IRWrite     = fetch_done;
  assign bus.MemtoReg    = ctrl_q.mem_to_reg;
  assign bus.RegDst      = ctrl_q.reg_dst;
  assign bus.RegWrite    = ctrl_q.reg_write;
  assign bus.halted      = ctrl_q.halted;
  assign bus.state       = state_q;

  // op_q is not loaded until DECODE ends, so the illegal flag has to be
  // decoded from the live IR field while DECODE is active.
  assign bus.illegal = (state_q == S_DECODE) && !opcode_legal;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed self-checking bench for multicycle_control.
//                Inputs change on the falling edge; outputs are sampled 1 ns
//                later, well away from the rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_if mc_bus();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mc_bus)
  );

  always #5 clk = ~clk;

  // All outputs except state, halted in the LSB
  logic [19:0] outs;
  assign outs = {mc_bus.ALUop, mc_bus.ALUSrcA, mc_bus.ALUSrcB, mc_bus.PCSource,
                 mc_bus.PCWrite, mc_bus.PCWriteCond, mc_bus.BranchNe,
                 mc_bus.IorD, mc_bus.MemRead, mc_bus.MemWrite, mc_bus.IRWrite,
                 mc_bus.MemtoReg, mc_bus.RegDst, mc_bus.RegWrite,
                 mc_bus.illegal, mc_bus.halted};

  // Stimulus only: pulse reset for one cycle; at the next falling edge the
  // DUT is in FETCH.
  task automatic apply_reset(input logic [3:0] op);
    @(negedge clk);
    reset            = 1'b1;
    mc_bus.mem_ready = 1'b1;
    mc_bus.opcode    = op;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mc_bus.state !== 4'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", mc_bus.state);
    end
    checks++;
    if (outs !== 20'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 00000", outs);
    end
    mc_bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== 20'h0) begin
      errors++; $display("FAIL reset_outputs_mem_ready: got %h expected 00000", outs);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (mc_bus.state !== 4'd0) begin
      errors++; $display("FAIL reset_release_no_edge: got %0d expected 0", mc_bus.state);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mc_bus.state !== 4'd1) begin
      errors++; $display("FAIL first_fetch: got %0d expected 1", mc_bus.state);
    end
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    apply_reset(4'b0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (mc_bus.state !== exp_st[i]) begin
        errors++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, mc_bus.state, exp_st[i]);
      end
      checks++;
      if (mc_bus.ALUop !== ((exp_st[i] == 4'd3) ? 3'b111 : 3'b000)) begin
        errors++; $display("FAIL rtype_aluop[%0d]: got %b in state %0d", i, mc_bus.ALUop, exp_st[i]);
      end
      checks++;
      if ({mc_bus.RegWrite, mc_bus.RegDst} !== ((exp_st[i] == 4'd4) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL rtype_regwrite_regdst[%0d]: got %b in state %0d", i,
                           {mc_bus.RegWrite, mc_bus.RegDst}, exp_st[i]);
      end
    end
  endtask

  // lw with one fetch wait cycle and two MEM_RD wait cycles
  task automatic test_lw_wait();
    logic [3:0] exp_st [9] = '{4'd1, 4'd1, 4'd2, 4'd7, 4'd8, 4'd8, 4'd8, 4'd9, 4'd1};
    logic       mr     [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] st;
    apply_reset(4'b0101);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      mc_bus.mem_ready = mr[i];
      #1;
      st = exp_st[i];
      checks++;
      if (mc_bus.state !== st) begin
        errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, mc_bus.state, st);
      end
      checks++;
      if (mc_bus.MemRead !== (st == 4'd1 || st == 4'd8)) begin
        errors++; $display("FAIL lw_memread[%0d]: got %b in state %0d", i, mc_bus.MemRead, st);
      end
      checks++;
      if (mc_bus.IorD !== (st == 4'd8)) begin
        errors++; $display("FAIL lw_iord[%0d]: got %b in state %0d", i, mc_bus.IorD, st);
      end
      checks++;
      if ({mc_bus.RegWrite, mc_bus.MemtoReg} !== ((st == 4'd9) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL lw_regwrite_memtoreg[%0d]: got %b in state %0d", i,
                           {mc_bus.RegWrite, mc_bus.MemtoReg}, st);
      end
      checks++;
      if ({mc_bus.IRWrite, mc_bus.PCWrite} !== ((st == 4'd1 && mr[i]) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL lw_fetch_strobes[%0d]: got %b state %0d mem_ready %b", i,
                           {mc_bus.IRWrite, mc_bus.PCWrite}, st, mr[i]);
      end
    end
  endtask

  // andi, ori, slti, addi back to back; opcode is scrambled after DECODE
  task automatic test_back_to_back();
    logic [3:0] ops [4] = '{4'b0010, 4'b0011, 4'b0100, 4'b0001};
    logic [2:0] alu [4] = '{3'b010, 3'b011, 3'b100, 3'b000};
    apply_reset(4'b0010);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mc_bus.opcode = ops[k];
      #1;
      checks++;
      if (mc_bus.state !== 4'd1) begin
        errors++; $display("FAIL itype_fetch[%0d]: got %0d expected 1", k, mc_bus.state);
      end
      @(negedge clk);
      #1;
      checks++;
      if (mc_bus.state !== 4'd2 || mc_bus.illegal !== 1'b0) begin
        errors++; $display("FAIL itype_decode[%0d]: state %0d illegal %b expected 2/0", k,
                           mc_bus.state, mc_bus.illegal);
      end
      checks++;
      if (mc_bus.ALUSrcB !== 2'b11) begin
        errors++; $display("FAIL itype_decode_srcb[%0d]: got %b expected 11", k, mc_bus.ALUSrcB);
      end
      @(negedge clk);
      mc_bus.opcode = 4'b1100;
      #1;
      checks++;
      if (mc_bus.state !== 4'd5) begin
        errors++; $display("FAIL itype_exec_state[%0d]: got %0d expected 5", k, mc_bus.state);
      end
      checks++;
      if (mc_bus.ALUop !== alu[k]) begin
        errors++; $display("FAIL itype_aluop[%0d]: got %b expected %b", k, mc_bus.ALUop, alu[k]);
      end
      checks++;
      if ({mc_bus.ALUSrcA, mc_bus.ALUSrcB} !== 3'b110) begin
        errors++; $display("FAIL itype_srcs[%0d]: got %b expected 110", k,
                           {mc_bus.ALUSrcA, mc_bus.ALUSrcB});
      end
      @(negedge clk);
      #1;
      checks++;
      if (mc_bus.state !== 4'd6 || mc_bus.RegWrite !== 1'b1 || mc_bus.RegDst !== 1'b0) begin
        errors++; $display("FAIL itype_wb[%0d]: state %0d RegWrite %b RegDst %b expected 6/1/0",
                           k, mc_bus.state, mc_bus.RegWrite, mc_bus.RegDst);
      end
    end
  endtask

  // bne, beq, j
  task automatic test_branch_jump();
    logic [3:0] ops    [3] = '{4'b1000, 4'b0111, 4'b1001};
    logic [3:0] exp_st [3] = '{4'd11, 4'd11, 4'd12};
    for (int k = 0; k < 3; k++) begin
      apply_reset(ops[k]);
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (mc_bus.state !== 4'd2) begin
        errors++; $display("FAIL br_decode[%0d]: got %0d expected 2", k, mc_bus.state);
      end
      @(negedge clk);
      #1;
      checks++;
      if (mc_bus.state !== exp_st[k]) begin
        errors++; $display("FAIL br_state[%0d]: got %0d expected %0d", k, mc_bus.state, exp_st[k]);
      end
      if (ops[k] == 4'b1001) begin
        checks++;
        if ({mc_bus.PCWrite, mc_bus.PCSource, mc_bus.PCWriteCond} !== 4'b1100) begin
          errors++; $display("FAIL jump_ctrl: got %b expected 1100",
                             {mc_bus.PCWrite, mc_bus.PCSource, mc_bus.PCWriteCond});
        end
      end else begin
        checks++;
        if ({mc_bus.ALUop, mc_bus.PCWriteCond, mc_bus.PCSource, mc_bus.PCWrite} !== 7'b0011010) begin
          errors++; $display("FAIL branch_ctrl[%0d]: got %b expected 0011010", k,
                             {mc_bus.ALUop, mc_bus.PCWriteCond, mc_bus.PCSource, mc_bus.PCWrite});
        end
        checks++;
        if ({mc_bus.ALUSrcA, mc_bus.ALUSrcB} !== 3'b100) begin
          errors++; $display("FAIL branch_srcs[%0d]: got %b expected 100", k,
                             {mc_bus.ALUSrcA, mc_bus.ALUSrcB});
        end
        checks++;
        if (mc_bus.BranchNe !== (ops[k] == 4'b1000)) begin
          errors++; $display("FAIL branch_ne[%0d]: got %b for opcode %b", k, mc_bus.BranchNe, ops[k]);
        end
      end
      @(negedge clk);
      #1;
      checks++;
      if (mc_bus.state !== 4'd1) begin
        errors++; $display("FAIL br_return_fetch[%0d]: got %0d expected 1", k, mc_bus.state);
      end
    end
  endtask

  task automatic test_illegal();
    apply_reset(4'b1100);
    @(negedge clk);
    #1;
    checks++;
    if (mc_bus.state !== 4'd1 || mc_bus.illegal !== 1'b0) begin
      errors++; $display("FAIL illegal_fetch: state %0d illegal %b expected 1/0", mc_bus.state, mc_bus.illegal);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mc_bus.state !== 4'd2 || mc_bus.illegal !== 1'b1) begin
      errors++; $display("FAIL illegal_decode: state %0d illegal %b expected 2/1", mc_bus.state, mc_bus.illegal);
    end
    checks++;
    if ({mc_bus.RegWrite, mc_bus.MemWrite} !== 2'b00) begin
      errors++; $display("FAIL illegal_no_write: got %b expected 00", {mc_bus.RegWrite, mc_bus.MemWrite});
    end
    @(negedge clk);
    #1;
    checks++;
    if (mc_bus.state !== 4'd1 || mc_bus.illegal !== 1'b0 || mc_bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL illegal_next: state %0d illegal %b RegWrite %b expected 1/0/0",
                         mc_bus.state, mc_bus.illegal, mc_bus.RegWrite);
    end
  endtask

  // sw stalled in MEM_WR, then reset asserted between clock edges
  task automatic test_reset_in_memwr();
    apply_reset(4'b0110);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mc_bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (mc_bus.state !== 4'd7) begin
      errors++; $display("FAIL sw_mem_addr: got %0d expected 7", mc_bus.state);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mc_bus.state !== 4'd10 || {mc_bus.MemWrite, mc_bus.IorD} !== 2'b11) begin
      errors++; $display("FAIL sw_mem_wr: state %0d MemWrite/IorD %b expected 10/11",
                         mc_bus.state, {mc_bus.MemWrite, mc_bus.IorD});
    end
    @(negedge clk);
    #1;
    checks++;
    if (mc_bus.state !== 4'd10 || mc_bus.MemWrite !== 1'b1) begin
      errors++; $display("FAIL sw_mem_wr_wait: state %0d MemWrite %b expected 10/1",
                         mc_bus.state, mc_bus.MemWrite);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (mc_bus.state !== 4'd0 || mc_bus.MemWrite !== 1'b0) begin
      errors++; $display("FAIL async_reset: state %0d MemWrite %b expected 0/0",
                         mc_bus.state, mc_bus.MemWrite);
    end
    checks++;
    if (outs !== 20'h0) begin
      errors++; $display("FAIL async_reset_outputs: got %h expected 00000", outs);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_halt();
    mc_bus.opcode    = 4'b1111;
    mc_bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mc_bus.state !== 4'd13 || mc_bus.halted !== 1'b1) begin
      errors++; $display("FAIL halt_enter: state %0d halted %b expected 13/1", mc_bus.state, mc_bus.halted);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mc_bus.mem_ready = i[0];
      mc_bus.opcode    = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (mc_bus.state !== 4'd13 || outs !== 20'h1) begin
        errors++; $display("FAIL halt_hold[%0d]: state %0d outputs %h expected 13/00001",
                           i, mc_bus.state, outs);
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    mc_bus.mem_ready = 1'b0;
    mc_bus.opcode    = 4'b0000;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_back_to_back();
    test_branch_jump();
    test_illegal();
    test_reset_in_memwr();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, expected bench to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Multicycle main control unit for the MiniMIPS processor. It is a Moore-style FSM (plus a few documented mem_ready-gated strobes) that sequences fetch, decode, execute, memory and write-back. It drives the datapath enables and muxes, and it produces the 3-bit ALUop consumed by the ALU control stage. It sits between the instruction register opcode field and the datapath, and handshakes with instruction/data memory through mem_ready.

## Interface
Parameters:
- none (opcode, ALUop and state encodings are fixed below)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces IDLE immediately
- opcode  input  4  IR[15:12]; sampled only in DECODE
- mem_ready  input  1  memory completes the current read/write this cycle
- ALUop  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 111 R-type (use Func); 101/110 never driven
- ALUSrcA  output  1  0=PC, 1=regA
- ALUSrcB  output  2  00=regB, 01=const 1, 10=sign-ext imm, 11=branch offset
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
- PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite  output  1 each  standard datapath controls
- illegal  output  1  high during DECODE when opcode is unmapped
- halted  output  1  high in HALT
- state  output  4  current state encoding, for debug

## Operation
- Opcode map: 0000 R-type, 0001 addi, 0010 andi, 0011 ori, 0100 slti, 0101 lw, 0110 sw, 0111 beq, 1000 bne, 1001 j, 1111 halt. 1010–1110 are illegal.
- DECODE registers opcode into op_q. Later states use op_q only.
- Default for every output is 0. Each state lists only its non-zero outputs.
- States (encoding) -> actions -> next state:
  - IDLE(0): none -> FETCH.
  - FETCH(1): MemRead, ALUSrcB=01, ALUop=000; IRWrite=PCWrite=mem_ready. Stay while !mem_ready; otherwise -> DECODE.
  - DECODE(2): ALUSrcB=11, ALUop=000.
    - R-type -> EXEC_R; addi/andi/ori/slti -> EXEC_I; lw/sw -> MEM_ADDR; beq/bne -> BRANCH; j -> JUMP; halt -> HALT.
    - Illegal opcode: illegal=1 -> FETCH.
  - EXEC_R(3): ALUSrcA=1, ALUSrcB=00, ALUop=111 -> WB_R.
  - WB_R(4): RegDst=1, RegWrite=1 -> FETCH.
  - EXEC_I(5): ALUSrcA=1, ALUSrcB=10; ALUop = addi 000, andi 010, ori 011, slti 100 -> WB_I.
  - WB_I(6): RegWrite=1 -> FETCH.
  - MEM_ADDR(7): ALUSrcA=1, ALUSrcB=10, ALUop=000 -> MEM_RD if op_q=lw, else MEM_WR.
  - MEM_RD(8): MemRead, IorD. Stay while !mem_ready; otherwise -> MEM_WB.
  - MEM_WB(9): RegWrite, MemtoReg -> FETCH.
  - MEM_WR(10): MemWrite, IorD. Stay while !mem_ready; otherwise -> FETCH.
  - BRANCH(11): ALUSrcA=1, ALUSrcB=00, ALUop=001, PCWriteCond=1, PCSource=01, BranchNe=(op_q==bne) -> FETCH.
  - JUMP(12): PCWrite=1, PCSource=10 -> FETCH.
  - HALT(13): halted=1; terminal, left only by reset.
- Encodings 14–15 are unreachable. If entered, the FSM goes to FETCH on the next edge with all outputs 0.

## Timing
- Reset values: state=0 (IDLE), all outputs 0, op_q=0000. Reset takes effect without waiting for a clock edge.
- Reset asserted mid-instruction: the in-flight access is abandoned. MemRead/MemWrite/RegWrite drop in the same cycle.
- First FETCH occurs on the first rising edge after reset deasserts.
- Cycles per instruction with zero memory wait: R/I-type 4, lw 5, sw 4, beq/bne 3, j 3, illegal 2. Each memory wait cycle adds 1.
- IRWrite and PCWrite in FETCH are combinational on mem_ready and pulse exactly one cycle per fetch.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- All non-strobe outputs are pure functions of state and op_q (glitch-free w.r.t. opcode).

## Test plan
- Reset, then deassert with mem_ready=1, opcode=0000: state walks 0→1→2→3→4→1. ALUop=111 only in EXEC_R. RegWrite=1, RegDst=1 only in WB_R.
- lw (0101) with mem_ready low for 2 cycles in MEM_RD: MEM_RD lasts 3 cycles with MemRead=IorD=1, then MEM_WB with RegWrite=MemtoReg=1. Total 7 cycles.
- andi, ori, slti, addi back-to-back: EXEC_I shows ALUop 010, 011, 100, 000 respectively. Also check bne gives BranchNe=1, PCWriteCond=1, ALUop=001, while beq gives BranchNe=0.
- Opcode 1100 in DECODE: illegal=1 for exactly 1 cycle, next state FETCH, no RegWrite/MemWrite asserted.
- Assert reset asynchronously mid-cycle in MEM_WR with MemWrite=1: MemWrite and state return to 0 before the next clock edge. Opcode 1111 reaches HALT, where halted stays 1 over 20 cycles regardless of mem_ready.
